// File: rtl/systolic_mm_array.sv
// systolic_mm_array: output-stationary unsigned matrix-multiply array
//
// Operands are loaded one word at a time (B columns first, then A rows).
// One full set of W+H words forms a wavefront. That wavefront is pushed
// skewed through an H x W grid of PEs. Each PE accumulates row*col into its
// own accumulator. Results are read out row-major, either by popping them
// one at a time with yumi_i or by streaming them all with flush_i.
//
// Ports:
//   clk_i     rising-edge clock
//   reset_i   asynchronous active-low reset, clears all state
//   en_i      global enable; when low all state holds
//   flush_i   start streaming all results (idle, pointer at slot 0 only)
//   ready_o   idle; a load word or a flush can be accepted
//   valid_i   data_i carries an operand word
//   data_i    operand word
//   valid_o   data_o holds a result
//   yumi_i    consumer pops the current result
//   data_o    current result, 0 when valid_o is low
//   busy_o    wavefront computing
//   onehot_o  {captured-slot mask, one-hot load pointer}
module systolic_mm_array #(
    parameter int width_p        = 8,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2
) (
    input  logic                                         clk_i,
    input  logic                                         reset_i,
    input  logic                                         en_i,
    input  logic                                         flush_i,
    output logic                                         ready_o,
    input  logic                                         valid_i,
    input  logic [width_p-1:0]                           data_i,
    output logic                                         valid_o,
    input  logic                                         yumi_i,
    output logic [width_p-1:0]                           data_o,
    output logic                                         busy_o,
    output logic [2*(array_width_p+array_height_p)-1:0]  onehot_o
);
    localparam int W  = array_width_p;
    localparam int H  = array_height_p;
    localparam int N  = W + H;
    localparam int M  = W * H;
    localparam int CW = $clog2(N + 1);
    localparam int RW = (M > 1) ? $clog2(M) : 1;

    logic [width_p-1:0] r_slot [N];
    logic [N-1:0]       r_ptr;
    logic [N-1:0]       r_cap;
    logic               r_busy;
    logic               r_stream;
    logic               r_done;
    logic [CW-1:0]      r_t;
    logic [RW-1:0]      r_rp;

    // w_a[r][c] / w_b[r][c] are the operands arriving at PE(r,c) this cycle
    logic [width_p-1:0] w_a  [H][W];
    logic               w_av [H][W];
    logic [width_p-1:0] w_b  [H][W];
    logic               w_bv [H][W];
    logic [width_p-1:0] w_acc [M];

    logic w_flush;
    logic w_load;
    logic w_adv;
    logic w_last;
    logic w_end;

    assign ready_o  = !r_busy && !r_stream;
    // A flush is only taken between loads, and it beats a same-cycle load word
    assign w_flush  = en_i && flush_i && ready_o && r_ptr[0];
    assign w_load   = en_i && valid_i && ready_o && !w_flush;
    assign valid_o  = r_done && !r_busy;
    assign data_o   = valid_o ? w_acc[r_rp] : '0;
    assign w_adv    = en_i && (w_flush || r_stream || (yumi_i && valid_o));
    assign w_last   = w_adv && (r_rp == RW'(M - 1));
    assign w_end    = en_i && r_busy && (r_t == CW'(N - 1));
    assign busy_o   = r_busy;
    assign onehot_o = {r_cap, r_ptr};

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int k = 0; k < N; k++) r_slot[k] <= '0;
            r_ptr    <= N'(1);
            r_cap    <= '0;
            r_busy   <= 1'b0;
            r_stream <= 1'b0;
            r_done   <= 1'b0;
            r_t      <= '0;
            r_rp     <= '0;
        end else if (en_i) begin
            if (w_load) begin
                for (int k = 0; k < N; k++) if (r_ptr[k]) r_slot[k] <= data_i;
                r_ptr <= {r_ptr[N-2:0], r_ptr[N-1]};
                r_cap <= r_cap | r_ptr;
                if (r_ptr[N-1]) r_busy <= 1'b1;
            end
            if (r_busy) begin
                r_t <= w_end ? '0 : r_t + 1'b1;
                if (w_end) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_cap  <= '0;
                end
            end
            if (w_adv) r_rp <= w_last ? '0 : r_rp + 1'b1;
            r_stream <= w_last ? 1'b0 : (w_flush ? 1'b1 : r_stream);
            if (w_last) r_done <= 1'b0;
        end
    end

    // Skewed injection: row r enters at step r, column c at step c, so both
    // operands meet in PE(r,c) at step r+c.
    for (genvar r = 0; r < H; r++) begin : g_rin
        assign w_a[r][0]  = r_slot[W+r];
        assign w_av[r][0] = r_busy && (r_t == CW'(r));
    end
    for (genvar c = 0; c < W; c++) begin : g_cin
        assign w_b[0][c]  = r_slot[c];
        assign w_bv[0][c] = r_busy && (r_t == CW'(c));
    end

    for (genvar r = 0; r < H; r++) begin : g_row
        for (genvar c = 0; c < W; c++) begin : g_col
            logic [width_p-1:0] r_acc;
            if (c < W - 1) begin : g_ap
                logic [width_p-1:0] r_a;
                logic               r_av;
                always_ff @(posedge clk_i or negedge reset_i) begin
                    if (!reset_i) begin
                        r_a  <= '0;
                        r_av <= 1'b0;
                    end else if (en_i) begin
                        r_a  <= w_a[r][c];
                        r_av <= w_av[r][c];
                    end
                end
                assign w_a[r][c+1]  = r_a;
                assign w_av[r][c+1] = r_av;
            end
            if (r < H - 1) begin : g_bp
                logic [width_p-1:0] r_b;
                logic               r_bv;
                always_ff @(posedge clk_i or negedge reset_i) begin
                    if (!reset_i) begin
                        r_b  <= '0;
                        r_bv <= 1'b0;
                    end else if (en_i) begin
                        r_b  <= w_b[r][c];
                        r_bv <= w_bv[r][c];
                    end
                end
                assign w_b[r+1][c]  = r_b;
                assign w_bv[r+1][c] = r_bv;
            end
            always_ff @(posedge clk_i or negedge reset_i) begin
                if (!reset_i) r_acc <= '0;
                else if (en_i) begin
                    if (w_last) r_acc <= '0;
                    else if (w_av[r][c] && w_bv[r][c]) r_acc <= r_acc + w_a[r][c] * w_b[r][c];
                end
            end
            assign w_acc[r*W+c] = r_acc;
        end
    end
endmodule

// File: tb/tb_systolic_mm_array.sv
// tb_systolic_mm_array: scoreboard bench for the 2x2 systolic matrix-multiply array
module tb_systolic_mm_array;
    logic       clk_i   = 1'b0;
    logic       reset_i = 1'b0;
    logic       en_i    = 1'b1;
    logic       flush_i = 1'b0;
    logic       valid_i = 1'b0;
    logic       yumi_i  = 1'b0;
    logic [7:0] data_i  = 8'h00;
    logic       ready_o;
    logic       valid_o;
    logic       busy_o;
    logic [7:0] data_o;
    logic [7:0] onehot_o;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] m_acc [4];
    bit         m_done;
    logic [7:0] q [$];

    systolic_mm_array #(.width_p(8), .array_width_p(2), .array_height_p(2)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .flush_i(flush_i),
        .ready_o(ready_o), .valid_i(valid_i), .data_i(data_i), .valid_o(valid_o),
        .yumi_i(yumi_i), .data_o(data_o), .busy_o(busy_o), .onehot_o(onehot_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_model;
        for (int i = 0; i < 4; i++) m_acc[i] = 8'h00;
        m_done = 1'b0;
    endtask

    // Loads one wavefront {col0,col1,row0,row1}; with hold, valid_i stays high through compute
    task automatic load_wave(input logic [7:0] w0, w1, w2, w3, input bit hold);
        logic [7:0] w [4];
        logic [7:0] p;
        int cnt;
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++) begin
            check("ready_ld", ready_o, 1);
            valid_i = 1'b1;
            data_i  = w[i];
            step;
        end
        valid_i = hold;
        data_i  = 8'hAA;
        check("busy_start", busy_o, 1);
        if (hold) check("onehot_busy", onehot_o, 8'hF1);
        cnt = 0;
        while (busy_o && cnt < 50) begin
            step;
            cnt++;
        end
        valid_i = 1'b0;
        check("busy_len", cnt, 4);
        check("ready_end", ready_o, 1);
        if (hold) check("onehot_idle", onehot_o, 8'h01);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                p = w[2+r] * w[c];
                m_acc[r*2+c] = m_acc[r*2+c] + p;
            end
        m_done = 1'b1;
    endtask

    task automatic push_expected(output bit ev);
        for (int i = 0; i < 4; i++) q.push_back(m_acc[i]);
        ev = m_done;
        clear_model();
    endtask

    task automatic stream_flush(input bit also_valid);
        bit ev;
        push_expected(ev);
        flush_i = 1'b1;
        valid_i = also_valid;
        data_i  = 8'h99;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("flush_vld", valid_o, ev);
            check("flush_data", data_o, q.pop_front());
            if (i > 0) check("flush_rdy", ready_o, 0);
            step;
            flush_i = 1'b0;
            valid_i = 1'b0;
        end
        @(negedge clk_i);
        check("post_vld", valid_o, 0);
        check("post_data", data_o, 0);
        check("post_rdy", ready_o, 1);
        check("post_ptr", onehot_o, 8'h01);
        step;
    endtask

    task automatic pop_all;
        bit ev;
        push_expected(ev);
        for (int i = 0; i < 4; i++) begin
            yumi_i = 1'b1;
            @(negedge clk_i);
            check("pop_vld", valid_o, ev);
            check("pop_data", data_o, q.pop_front());
            step;
            yumi_i = 1'b0;
            step;
        end
        @(negedge clk_i);
        check("pop_end_vld", valid_o, 0);
        check("pop_end_data", data_o, 0);
        step;
    endtask

    initial begin
        clear_model();
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_hold_rdy", ready_o, 1);
        reset_i = 1'b1;
        step;
        check("rst_rdy", ready_o, 1);
        check("rst_vld", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_onehot", onehot_o, 8'h01);

        load_wave(3, 4, 2, 4, 0);
        load_wave(1, 2, 1, 3, 0);
        stream_flush(0);

        load_wave(3, 4, 2, 4, 0);
        load_wave(1, 2, 1, 3, 0);
        pop_all();

        load_wave(255, 255, 255, 255, 0);
        stream_flush(1);

        load_wave(5, 6, 7, 8, 1);
        stream_flush(0);

        load_wave(1, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1;
            data_i  = 8'(i + 9);
            step;
        end
        valid_i = 1'b0;
        step;
        check("mid_busy", busy_o, 1);
        reset_i = 1'b0;
        #1;
        check("arst_rdy", ready_o, 1);
        check("arst_vld", valid_o, 0);
        check("arst_data", data_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_onehot", onehot_o, 8'h01);
        step;
        reset_i = 1'b1;
        step;
        clear_model();
        stream_flush(0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
